// File: rtl/vga_dispatch_pkg.sv
// Shared encodings for the instruction dispatcher.
//   S_*  : dispatcher FSM states (IDLE, ISSUE, WAIT)
//   ST_* : status_code values reported to the CPU interface
package vga_dispatch_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_ENG_ERR  = 2'd1;
  localparam logic [1:0] ST_UNMAPPED = 2'd2;
  localparam logic [1:0] ST_TIMEOUT  = 2'd3;

endpackage

// File: rtl/dispatch_watchdog.sv
// Saturating cycle counter that flags when an engine has been waited on for
// too long.
//   clk     in  rising-edge clock
//   rst     in  asynchronous active-high reset
//   clear   in  restart the count from 0
//   enable  in  count this cycle (one WAIT cycle)
//   expired out count has reached TIMEOUT_CYCLES-1; held until clear
module dispatch_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The last value reached is TIMEOUT_CYCLES-1, which always fits here.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      // Saturates at LAST; it never wraps back to zero.
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// Routes instruction-start commands to one of NUM_ENGINES engines by opcode
// group, tracks one outstanding instruction, and reports sticky status.
//   clk_25mhz, reset          clock / asynchronous active-high reset
//   cmd_valid, cmd_opcode     one-cycle command from the CPU interface
//   abort                     cancel the outstanding instruction
//   cmd_ready                 high while IDLE
//   eng_start, eng_opcode     one-hot start pulse and latched opcode to engines
//   eng_busy/finished/error/result  per-engine handshake and result inputs
//   status_busy/finished/error/code/overrun, result   status back to the CPU
module instruction_dispatcher
  import vga_dispatch_pkg::*;
#(
  parameter int NUM_ENGINES    = 2,
  parameter int OPCODE_W       = 8,
  parameter int GROUP_BITS     = 4,
  parameter int RESULT_W       = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk_25mhz,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic [OPCODE_W-1:0]           cmd_opcode,
  input  logic                          abort,
  output logic                          cmd_ready,
  output logic [NUM_ENGINES-1:0]        eng_start,
  output logic [OPCODE_W-1:0]           eng_opcode,
  input  logic [NUM_ENGINES-1:0]        eng_busy,
  input  logic [NUM_ENGINES-1:0]        eng_finished,
  input  logic [NUM_ENGINES-1:0]        eng_error,
  input  logic [NUM_ENGINES*RESULT_W-1:0] eng_result,
  output logic                          status_busy,
  output logic                          status_finished,
  output logic                          status_error,
  output logic [1:0]                    status_code,
  output logic                          status_overrun,
  output logic [RESULT_W-1:0]           result
);

  localparam int SEL_W = OPCODE_W - GROUP_BITS;
  localparam int ENG_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  logic [1:0]          state;
  logic [ENG_W-1:0]    sel_q;
  logic                wait_first;
  logic [SEL_W-1:0]    sel_full;
  logic                mapped;
  logic                sel_finished;
  logic                sel_error;
  logic [RESULT_W-1:0] sel_result;
  logic                wd_expired;

  // Engine busy is informational only; nothing in the dispatcher depends on it.
  logic unused_busy;
  assign unused_busy = ^eng_busy;

  // Extra leading zero so NUM_ENGINES == 2**SEL_W still compares correctly.
  assign sel_full = cmd_opcode[OPCODE_W-1:GROUP_BITS];
  assign mapped   = ({1'b0, sel_full} < (SEL_W + 1)'(NUM_ENGINES));

  assign sel_finished = eng_finished[sel_q];
  assign sel_error    = eng_error[sel_q];
  assign sel_result   = eng_result[int'(sel_q) * RESULT_W +: RESULT_W];

  assign cmd_ready   = (state == S_IDLE);
  assign status_busy = (state != S_IDLE);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    eng_start = '0;
    if (state == S_ISSUE) eng_start[sel_q] = 1'b1;
  end

  dispatch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk_25mhz),
    .rst     (reset),
    .clear   (state == S_ISSUE),
    .enable  (state == S_WAIT),
    .expired (wd_expired)
  );

  // NOTE: every flop here, including the captured result, is put in the
  // reset branch: the CPU reads result and status right after reset.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      sel_q           <= '0;
      wait_first      <= 1'b0;
      eng_opcode      <= '0;
      status_finished <= 1'b0;
      status_error    <= 1'b0;
      status_code     <= ST_OK;
      status_overrun  <= 1'b0;
      result          <= '0;
    end else begin
      if (cmd_valid && state != S_IDLE) status_overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            status_overrun <= 1'b0;
            if (mapped) begin
              eng_opcode      <= cmd_opcode;
              sel_q           <= sel_full[ENG_W-1:0];
              status_finished <= 1'b0;
              status_error    <= 1'b0;
              status_code     <= ST_OK;
              state           <= S_ISSUE;
            end else begin
              // Unmapped opcodes complete immediately with an error.
              status_finished <= 1'b1;
              status_error    <= 1'b1;
              status_code     <= ST_UNMAPPED;
            end
          end
        end

        S_ISSUE: begin
          wait_first <= 1'b1;
          if (abort) begin
            status_finished <= 1'b1;
            status_error    <= 1'b1;
            status_code     <= ST_TIMEOUT;
            state           <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          wait_first <= 1'b0;
          // The engine may still show the previous finished level during the
          // first WAIT cycle; finish then takes priority over abort/timeout.
          if (!wait_first && sel_finished) begin
            result          <= sel_result;
            status_finished <= 1'b1;
            status_error    <= sel_error;
            status_code     <= sel_error ? ST_ENG_ERR : ST_OK;
            state           <= S_IDLE;
          end else if (abort || wd_expired) begin
            status_finished <= 1'b1;
            status_error    <= 1'b1;
            status_code     <= ST_TIMEOUT;
            state           <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed bench for instruction_dispatcher (2 engines, 8-bit opcodes,
// 16-bit results, watchdog of 8 WAIT cycles). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_instruction_dispatcher;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic        abort;
  logic        cmd_ready;
  logic [1:0]  eng_start;
  logic [7:0]  eng_opcode;
  logic [1:0]  eng_busy;
  logic [1:0]  eng_finished;
  logic [1:0]  eng_error;
  logic [31:0] eng_result;
  logic        status_busy;
  logic        status_finished;
  logic        status_error;
  logic [1:0]  status_code;
  logic        status_overrun;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;
  int starts0 = 0;
  int starts1 = 0;

  // {cmd_ready, busy, finished, error, overrun, code[1:0]}
  logic [6:0] st;
  assign st = {cmd_ready, status_busy, status_finished, status_error,
               status_overrun, status_code};

  instruction_dispatcher #(
    .NUM_ENGINES    (2),
    .OPCODE_W       (8),
    .GROUP_BITS     (4),
    .RESULT_W       (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_25mhz       (clk_25mhz),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_opcode      (cmd_opcode),
    .abort           (abort),
    .cmd_ready       (cmd_ready),
    .eng_start       (eng_start),
    .eng_opcode      (eng_opcode),
    .eng_busy        (eng_busy),
    .eng_finished    (eng_finished),
    .eng_error       (eng_error),
    .eng_result      (eng_result),
    .status_busy     (status_busy),
    .status_finished (status_finished),
    .status_error    (status_error),
    .status_code     (status_code),
    .status_overrun  (status_overrun),
    .result          (result)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  // Count start pulses per engine, sampled mid-cycle.
  always @(negedge clk_25mhz) begin
    if (eng_start[0]) starts0++;
    if (eng_start[1]) starts1++;
  end

  task automatic tick;
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic accept(input logic [7:0] op);
    cmd_opcode = op;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; abort = 1'b0;
    eng_busy = '0; eng_finished = '0; eng_error = '0; eng_result = '0;
    tick(); tick();
    total++; if (st !== 7'b1000000) begin bad++; $display("FAIL reset_status: got %b want 1000000", st); end
    total++; if (eng_start !== 2'b00) begin bad++; $display("FAIL reset_start: got %b want 00", eng_start); end
    total++; if (eng_opcode !== 8'h00) begin bad++; $display("FAIL reset_opcode: got %h want 00", eng_opcode); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_ok;
    int s0 = starts0;
    accept(8'h03);
    total++; if (eng_start !== 2'b01) begin bad++; $display("FAIL t1_start: got %b want 01", eng_start); end
    total++; if (st !== 7'b0100000) begin bad++; $display("FAIL t1_issue_status: got %b want 0100000", st); end
    total++; if (eng_opcode !== 8'h03) begin bad++; $display("FAIL t1_opcode: got %h want 03", eng_opcode); end
    tick();
    total++; if (eng_start !== 2'b00) begin bad++; $display("FAIL t1_start_width: got %b want 00", eng_start); end
    repeat (4) tick();
    eng_result = 32'h0000_4141; eng_finished = 2'b01;
    tick();
    eng_finished = 2'b00;
    total++; if (st !== 7'b1010000) begin bad++; $display("FAIL t1_done_status: got %b want 1010000", st); end
    total++; if (result !== 16'h4141) begin bad++; $display("FAIL t1_result: got %h want 4141", result); end
    total++; if (starts0 - s0 !== 1) begin bad++; $display("FAIL t1_start_count: got %0d want 1", starts0 - s0); end
  endtask

  task automatic test_engine_error;
    accept(8'h12);
    total++; if (eng_start !== 2'b10) begin bad++; $display("FAIL t2_start: got %b want 10", eng_start); end
    total++; if (st !== 7'b0100000) begin bad++; $display("FAIL t2_cleared_on_accept: got %b want 0100000", st); end
    tick(); tick();
    eng_result = 32'hBEEF_0000; eng_error = 2'b10; eng_finished = 2'b10;
    tick();
    eng_finished = 2'b00; eng_error = 2'b00;
    total++; if (st !== 7'b1011001) begin bad++; $display("FAIL t2_done_status: got %b want 1011001", st); end
    total++; if (result !== 16'hBEEF) begin bad++; $display("FAIL t2_result: got %h want beef", result); end
  endtask

  task automatic test_first_wait_ignored;
    accept(8'h04);
    // Stale finished level already present when the engine is started.
    eng_result = 32'h0000_1234; eng_finished = 2'b01;
    tick();  // now first WAIT cycle
    tick();  // first WAIT cycle ignored the level
    total++; if (status_busy !== 1'b1) begin bad++; $display("FAIL fw_still_busy: got %b want 1", status_busy); end
    tick();
    eng_finished = 2'b00;
    total++; if (st !== 7'b1010000) begin bad++; $display("FAIL fw_done_status: got %b want 1010000", st); end
    total++; if (result !== 16'h1234) begin bad++; $display("FAIL fw_result: got %h want 1234", result); end
  endtask

  task automatic test_unmapped;
    int s0 = starts0;
    int s1 = starts1;
    accept(8'h25);
    total++; if (st !== 7'b1011010) begin bad++; $display("FAIL t3_status: got %b want 1011010", st); end
    total++; if (eng_start !== 2'b00) begin bad++; $display("FAIL t3_start: got %b want 00", eng_start); end
    tick();
    total++; if ((starts0 - s0) + (starts1 - s1) !== 0) begin bad++; $display("FAIL t3_no_start: got %0d want 0", (starts0 - s0) + (starts1 - s1)); end
    total++; if (result !== 16'h1234) begin bad++; $display("FAIL t3_result: got %h want 1234", result); end
  endtask

  task automatic test_timeout;
    accept(8'h01);
    total++; if (eng_start !== 2'b01) begin bad++; $display("FAIL t4_start: got %b want 01", eng_start); end
    repeat (8) tick();  // eighth WAIT cycle in progress
    total++; if (status_busy !== 1'b1) begin bad++; $display("FAIL t4_busy_before: got %b want 1", status_busy); end
    tick();
    total++; if (st !== 7'b1011011) begin bad++; $display("FAIL t4_timeout_status: got %b want 1011011", st); end
    total++; if (result !== 16'h1234) begin bad++; $display("FAIL t4_result: got %h want 1234", result); end
    eng_result = 32'h0000_DEAD; eng_finished = 2'b01;
    tick(); tick();
    eng_finished = 2'b00;
    total++; if (st !== 7'b1011011) begin bad++; $display("FAIL t4_late_status: got %b want 1011011", st); end
    total++; if (result !== 16'h1234) begin bad++; $display("FAIL t4_late_result: got %h want 1234", result); end
  endtask

  task automatic test_overrun_abort;
    int s1 = starts1;
    accept(8'h10);
    cmd_opcode = 8'h11; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++; if (st !== 7'b0100100) begin bad++; $display("FAIL t5_overrun: got %b want 0100100", st); end
    total++; if (eng_opcode !== 8'h10) begin bad++; $display("FAIL t5_opcode_kept: got %h want 10", eng_opcode); end
    tick();
    eng_result = 32'h5555_0000; eng_finished = 2'b10; abort = 1'b1;
    tick();
    eng_finished = 2'b00; abort = 1'b0;
    total++; if (st !== 7'b1010100) begin bad++; $display("FAIL t5_finish_beats_abort: got %b want 1010100", st); end
    total++; if (result !== 16'h5555) begin bad++; $display("FAIL t5_result: got %h want 5555", result); end
    total++; if (starts1 - s1 !== 1) begin bad++; $display("FAIL t5_start_count: got %0d want 1", starts1 - s1); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (st !== 7'b1010100) begin bad++; $display("FAIL t5_idle_abort: got %b want 1010100", st); end
  endtask

  task automatic test_abort;
    accept(8'h02);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (st !== 7'b1011011) begin bad++; $display("FAIL ab_status: got %b want 1011011", st); end
    total++; if (result !== 16'h5555) begin bad++; $display("FAIL ab_result: got %h want 5555", result); end
  endtask

  task automatic test_reset_mid;
    int s0;
    accept(8'h05);
    tick(); tick();
    s0 = starts0;
    reset = 1'b1;
    #1;
    total++; if (st !== 7'b1000000) begin bad++; $display("FAIL t6_async_status: got %b want 1000000", st); end
    total++; if (eng_opcode !== 8'h00) begin bad++; $display("FAIL t6_async_opcode: got %h want 00", eng_opcode); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL t6_async_result: got %h want 0000", result); end
    tick();
    #2 reset = 1'b0;
    repeat (5) tick();
    total++; if (starts0 - s0 !== 0) begin bad++; $display("FAIL t6_no_start: got %0d want 0", starts0 - s0); end
    total++; if (st !== 7'b1000000) begin bad++; $display("FAIL t6_after_release: got %b want 1000000", st); end
  endtask

  initial begin
    test_reset();
    test_single_ok();
    test_engine_error();
    test_first_wait_ignored();
    test_unmapped();
    test_timeout();
    test_overrun_abort();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
